ps: RTL and testbench

- ASCON substitution layer (pS), applying the 5-bit ASCON S-box to each of the 64 bit-columns of the 320-bit state.
- Sits in the permutation datapath between the constant-addition layer (pC) and the linear diffusion layer (pL).
- Default build registers the result with one cycle of latency.

---
 rtl/ps.sv | 119 +++++++++++
 tb/tb_ps.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps.sv
// ---------------------------------------------------------------------------
// ps : ASCON substitution layer (pS)
//
// Applies the 5-bit ASCON S-box to each of the 64 bit-columns of the 320-bit
// permutation state. It sits between constant addition (pC) and linear
// diffusion (pL). The state is five 64-bit words packed MSB first, so word 0
// (x0) is the most-significant 64 bits of the 320-bit value.
//
// Ports:
//   clock_i        in   1    system clock, rising edge
//   resetb_i       in   1    asynchronous active-low reset
//   en_i           in   1    capture enable
//   state_i        in   320  state after pC (5 x 64-bit words, x0 first)
//   substitution_o out  320  substituted state
//   valid_o        out  1    high for one cycle per newly computed result
//
// Build option:
//   PS_COMB_EN  when defined, the layer is purely combinational:
//               substitution_o = S(state_i) and valid_o = en_i, with clock_i
//               and resetb_i unused. When undefined (default), the result is
//               registered with one cycle of latency.
// ---------------------------------------------------------------------------
module ps (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             en_i,
    input  logic [0:4][63:0] state_i,
    output logic [0:4][63:0] substitution_o,
    output logic             valid_o
);

    // ASCON 5-bit S-box as a lookup table. The index is one bit-column with
    // x0 as the MSB and x4 as the LSB; the result maps back the same way.
    function automatic logic [4:0] sbox_lut(input logic [4:0] idx);
        logic [4:0] res;
        case (idx)
            5'd0:  res = 5'h04;
            5'd1:  res = 5'h0b;
            5'd2:  res = 5'h1f;
            5'd3:  res = 5'h14;
            5'd4:  res = 5'h1a;
            5'd5:  res = 5'h15;
            5'd6:  res = 5'h09;
            5'd7:  res = 5'h02;
            5'd8:  res = 5'h1b;
            5'd9:  res = 5'h05;
            5'd10: res = 5'h08;
            5'd11: res = 5'h12;
            5'd12: res = 5'h1d;
            5'd13: res = 5'h03;
            5'd14: res = 5'h06;
            5'd15: res = 5'h1c;
            5'd16: res = 5'h1e;
            5'd17: res = 5'h13;
            5'd18: res = 5'h07;
            5'd19: res = 5'h0e;
            5'd20: res = 5'h00;
            5'd21: res = 5'h0d;
            5'd22: res = 5'h11;
            5'd23: res = 5'h18;
            5'd24: res = 5'h10;
            5'd25: res = 5'h0c;
            5'd26: res = 5'h01;
            5'd27: res = 5'h19;
            5'd28: res = 5'h16;
            5'd29: res = 5'h0a;
            5'd30: res = 5'h0f;
            default: res = 5'h17;
        endcase
        return res;
    endfunction

    logic [0:4][63:0] sub_state;

    // Every column is an independent S-box instance: gather bit j of each
    // word into an index, look it up, and scatter the result back to bit j.
    for (genvar j = 0; j < 64; j++) begin : g_col
        logic [4:0] col_out;

        assign col_out = sbox_lut({state_i[0][j], state_i[1][j], state_i[2][j],
                                   state_i[3][j], state_i[4][j]});

        assign sub_state[0][j] = col_out[4];
        assign sub_state[1][j] = col_out[3];
        assign sub_state[2][j] = col_out[2];
        assign sub_state[3][j] = col_out[1];
        assign sub_state[4][j] = col_out[0];
    end

`ifdef PS_COMB_EN

    // Zero-latency build: the S-box network drives the outputs directly.
    // Clock and reset are tied into a dummy net so they stay connected.
    logic unused_clk_rst;

    assign unused_clk_rst = clock_i ^ resetb_i;
    assign substitution_o = sub_state;
    assign valid_o        = en_i;

`else

    // Registered build: capture the substituted state on enable. With the
    // enable low the previous result is held, but valid drops so that each
    // result is flagged exactly once. Reset clears both immediately.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            substitution_o <= '0;
            valid_o        <= 1'b0;
        end else if (en_i) begin
            substitution_o <= sub_state;
            valid_o        <= 1'b1;
        end else begin
            valid_o        <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_ps.sv
// ---------------------------------------------------------------------------
// tb_ps : self-checking bench for the ASCON substitution layer ps
//
// Drives states on the falling edge and pushes the expected output (valid
// flag and state) for the following rising edge into a queue. A monitor
// samples one time unit after each rising edge and compares against the
// head of the queue. The reference is an independent bitsliced model of the
// ASCON S-box, plus hand-derived constants for the simple states.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps;

    typedef struct {
        logic         v;
        logic [319:0] d;
        string        tag;
    } exp_t;

    logic         clock;
    logic         resetb;
    logic         en;
    logic [319:0] state;
    logic [319:0] substitution;
    logic         valid;

    exp_t         exp_q[$];
    logic [319:0] last_data;
    int           check_count;
    int           error_count;

    ps dut (
        .clock_i        (clock),
        .resetb_i       (resetb),
        .en_i           (en),
        .state_i        (state),
        .substitution_o (substitution),
        .valid_o        (valid)
    );

    // 20 ns clock period
    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    // Global watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Bitsliced ASCON S-box reference over all 64 columns at once
    function automatic logic [319:0] sboxModel(input logic [319:0] s);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input logic [319:0] actual,
                               input logic [319:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show after the
    // next rising edge. With enable low the held output is expected.
    task automatic applyStimulus(input logic e, input logic [319:0] st,
                                 input logic [319:0] exp_d, input string tag);
        exp_t item;
        @(negedge clock);
        en    = e;
        state = st;
        if (e) last_data = exp_d;
        item.v   = e;
        item.d   = last_data;
        item.tag = tag;
        exp_q.push_back(item);
    endtask

    // Monitor: sample after each rising edge, compare with the queue head
    initial begin
        exp_t item;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                checkOutput({item.tag, ".valid"}, {319'b0, valid}, {319'b0, item.v});
                checkOutput({item.tag, ".data"}, substitution, item.d);
            end
        end
    end

    logic [319:0] col_state;
    logic [319:0] vec_state;
    logic [319:0] rnd;
    logic [4:0]   idx;
    int           drain;

    initial begin
        check_count = 0;
        error_count = 0;
        last_data   = '0;
        resetb      = 1'b0;
        en          = 1'b0;
        state       = {320{1'b1}};

        // Reset state with enable and inputs active
        en = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset.valid", {319'b0, valid}, 320'b0);
        checkOutput("reset.data", substitution, 320'b0);
        en = 1'b0;
        resetb = 1'b1;

        // Simple hand-derived states
        applyStimulus(1'b1, 320'b0,
                      {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0}, "zero");
        applyStimulus(1'b1, {320{1'b1}},
                      {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF,
                       64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}, "ones");
        applyStimulus(1'b1, {256'b0, 64'h1},
                      {64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFE, 64'h1, 64'h1}, "x4one");

        // Every S-box index on columns 0..31, replicated on columns 32..63
        col_state = '0;
        for (int j = 0; j < 64; j++) begin
            idx = 5'(j % 32);
            col_state[256 + j] = idx[4];
            col_state[192 + j] = idx[3];
            col_state[128 + j] = idx[2];
            col_state[64 + j]  = idx[1];
            col_state[j]       = idx[0];
        end
        applyStimulus(1'b1, col_state, sboxModel(col_state), "table");

        // First-round ASCON-128 initialisation vector
        vec_state = 320'h00001000808c0001_6cb10ad9ca912f80_691aed630e8190ef_0c4c36a20853217c_46487b3e06d9d7a8;
        applyStimulus(1'b1, vec_state, sboxModel(vec_state), "ascon_iv");

        // Enable low for three cycles: output holds, valid low
        for (int k = 0; k < 3; k++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b0, rnd, 320'b0, "hold");
        end

        // Back-to-back random states
        for (int k = 0; k < 4; k++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b1, rnd, sboxModel(rnd), "b2b");
        end

        // Asynchronous reset pulse between clock edges
        @(posedge clock);
        #3;
        resetb = 1'b0;
        #1;
        checkOutput("async_rst.valid", {319'b0, valid}, 320'b0);
        checkOutput("async_rst.data", substitution, 320'b0);
        #2;
        resetb = 1'b1;
        exp_q.delete();
        last_data = '0;

        // After reset: nothing valid until enable, then normal operation
        applyStimulus(1'b0, vec_state, 320'b0, "post_rst_idle");
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
        applyStimulus(1'b1, rnd, sboxModel(rnd), "post_rst");
        applyStimulus(1'b0, 320'b0, 320'b0, "post_rst_hold");

        // Let the monitor drain the queue within a bounded number of cycles
        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        #2;
        checkOutput("drain", 320'(exp_q.size()), 320'b0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
